// File: rtl/cpu_multicycle_ctrl.sv
// Multicycle control FSM for CPU_V1: fetches one ARM data-processing word per
// instruction over a req/ack handshake, then executes ADD / ADD-immediate.
module cpu_multicycle_ctrl #(
  parameter int DATA_W       = 32,
  parameter int COUNT_W      = 16,
  parameter int IMEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [DATA_W-1:0]  imem_rdata,
  output logic               pc_en,
  output logic [3:0]         ra1,
  output logic [3:0]         ra2,
  output logic [3:0]         wa3,
  output logic               alu_src_imm,
  output logic [DATA_W-1:0]  imm_ext,
  output logic               rf_we,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic               timeout,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int TO_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(IMEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  state_t             state, state_nx;
  logic [DATA_W-1:0]  ir;
  logic               stop_lat;
  logic [TO_W-1:0]    to_cnt;
  logic               ir_ld, to_clr, to_inc, set_ill, set_tmo, cnt_inc, boundary;
  logic               is_add, cond_al, dec_vld;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  // A legal ADD: op=00, cmd=0100 (S bit free), and no shift/rotate encoded.
  assign is_add  = (ir[27:26] == 2'b00) && (ir[24:20] ==? 5'b0100?) &&
                   (ir[25] ? (ir[11:8] == 4'h0) : (ir[11:4] == 8'h00));
  assign cond_al = (ir[31:28] == 4'hE);

  always_comb begin
    state_nx = state;
    ir_ld    = 1'b0;
    to_clr   = 1'b0;
    to_inc   = 1'b0;
    set_ill  = 1'b0;
    set_tmo  = 1'b0;
    cnt_inc  = 1'b0;
    boundary = 1'b0;
    imem_req = 1'b0;
    pc_en    = 1'b0;
    rf_we    = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_ld    = 1'b1;
          to_clr   = 1'b1;
          state_nx = S_DECODE;
        end else if (to_cnt == TO_LAST) begin
          set_tmo  = 1'b1;
          to_clr   = 1'b1;
          state_nx = S_HALT;
        end else begin
          to_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_add && cond_al) begin
          state_nx = S_EXECUTE;
        end else if (is_add) begin
          pc_en    = 1'b1;
          boundary = 1'b1;
        end else begin
          set_ill  = 1'b1;
          state_nx = S_HALT;
        end
      end
      S_EXECUTE: state_nx = S_WRITEBACK;
      S_WRITEBACK: begin
        rf_we    = 1'b1;
        pc_en    = 1'b1;
        cnt_inc  = 1'b1;
        boundary = 1'b1;
      end
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
    if (boundary) state_nx = (stop_lat || stop) ? S_IDLE : S_FETCH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ir          <= '0;
      stop_lat    <= 1'b0;
      to_cnt      <= '0;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
      instr_count <= '0;
    end else begin
      state    <= state_nx;
      // A stop seen while busy is held until the next instruction boundary.
      stop_lat <= busy && !boundary && (stop_lat || stop);
      if (ir_ld)        ir     <= imem_rdata;
      if (to_clr)       to_cnt <= '0;
      else if (to_inc)  to_cnt <= to_cnt + TO_W'(1);
      if (set_ill)      illegal <= 1'b1;
      if (set_tmo)      timeout <= 1'b1;
      if (cnt_inc)      instr_count <= sat_inc(instr_count);
    end
  end

  assign busy    = (state == S_FETCH) || (state == S_DECODE) ||
                   (state == S_EXECUTE) || (state == S_WRITEBACK);
  assign halted  = (state == S_HALT);
  assign dec_vld = (state == S_DECODE) || (state == S_EXECUTE) || (state == S_WRITEBACK);

  assign ra1         = dec_vld ? ir[19:16] : 4'h0;
  assign ra2         = dec_vld ? ir[3:0]   : 4'h0;
  assign wa3         = dec_vld ? ir[15:12] : 4'h0;
  assign alu_src_imm = dec_vld && ir[25];
  assign imm_ext     = dec_vld ? DATA_W'(ir[7:0]) : '0;

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Bench for cpu_multicycle_ctrl: table-driven ADD sequence, directed corner
// cases and randomized instruction streams against a per-instruction model.
module tb_cpu_multicycle_ctrl;
  localparam int CW   = 4;
  localparam int TO   = 15;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, start, stop, imem_ack;
  logic [31:0] imem_rdata;
  logic imem_req, pc_en, rf_we, busy, halted, illegal, timeout, alu_src_imm;
  logic [3:0] ra1, ra2, wa3;
  logic [31:0] imm_ext;
  logic [CW-1:0] instr_count;

  typedef struct packed {
    logic req, pc_en, rf_we, busy, halted, ill, tmo, src;
    logic [3:0] ra1, ra2, wa3;
    logic [31:0] imm;
    logic [CW-1:0] cnt;
  } obs_t;

  typedef struct {
    string nm;
    bit ack;
    logic [31:0] rd;
    bit st;
    bit sp;
    obs_t e;
  } vec_t;

  obs_t act;
  assign act = {imem_req, pc_en, rf_we, busy, halted, illegal, timeout, alu_src_imm,
                ra1, ra2, wa3, imm_ext, instr_count};

  int total = 0;
  int bad = 0;
  int m_cnt = 0;
  bit m_ill = 0, m_tmo = 0, stop_pend = 0, at_idle = 1;

  cpu_multicycle_ctrl #(.DATA_W(32), .COUNT_W(CW), .IMEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_en(pc_en), .ra1(ra1), .ra2(ra2), .wa3(wa3), .alu_src_imm(alu_src_imm),
    .imm_ext(imm_ext), .rf_we(rf_we), .busy(busy), .halted(halted),
    .illegal(illegal), .timeout(timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(bit req, bit pc, bit we, bit bsy, bit hlt, bit dec,
                              logic [31:0] w);
    obs_t o;
    o = '0;
    o.req = req; o.pc_en = pc; o.rf_we = we; o.busy = bsy; o.halted = hlt;
    o.ill = m_ill; o.tmo = m_tmo; o.cnt = CW'(m_cnt);
    if (dec) begin
      o.src = w[25]; o.ra1 = w[19:16]; o.ra2 = w[3:0]; o.wa3 = w[15:12];
      o.imm = {24'h0, w[7:0]};
    end
    return o;
  endfunction

  // 0 = executes, 1 = skipped on condition, 2 = illegal
  function automatic int classify(logic [31:0] w);
    logic [31:0] nc;
    nc = {4'hE, w[27:0]};
    if (((nc & 32'hFFE00FF0) == 32'hE0800000) || ((nc & 32'hFFE00F00) == 32'hE2800000))
      return (w[31:28] == 4'hE) ? 0 : 1;
    return 2;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    logic [3:0] c;
    r = $urandom;
    c = 4'($urandom_range(0, 14));
    if (c == 4'hE) c = 4'hF;
    case ($urandom_range(0, 2))
      0: return 32'hE0800000 | (r & 32'h001FF00F);
      1: return 32'hE2800000 | (r & 32'h001FF0FF);
      default: return {c, 28'h0800000} | (r & 32'h001FF00F);
    endcase
  endfunction

  task automatic chk(input obs_t e, input string nm);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, e);
    end
  endtask

  task automatic cycle(input obs_t e, input string nm, input bit ack,
                       input logic [31:0] rd, input bit st, input bit sp);
    @(negedge clk);
    chk(e, nm);
    imem_ack = ack; imem_rdata = rd; start = st; stop = sp;
    if (sp && e.busy) stop_pend = 1;
  endtask

  task automatic launch();
    cycle(mk(0, 0, 0, 0, 0, 0, 0), "idle", 0, $urandom, 1, 0);
    at_idle = 0;
  endtask

  task automatic do_reset(input bit now);
    if (!now) @(negedge clk);
    reset = 0; start = 0; stop = 0; imem_ack = 0;
    #1;
    m_cnt = 0; m_ill = 0; m_tmo = 0; stop_pend = 0; at_idle = 1;
    chk(mk(0, 0, 0, 0, 0, 0, 0), "reset");
    @(negedge clk);
    reset = 1;
  endtask

  // Drives one instruction from its first FETCH cycle; sp_at selects the
  // cycle (counted from FETCH) in which stop is pulsed, -1 for none.
  task automatic run_instr(input logic [31:0] w, input int d, input int sp_at);
    int k;
    int cls;
    k = 0;
    cls = classify(w);
    for (int c = 0; c <= d; c++) begin
      cycle(mk(1, 0, 0, 1, 0, 0, 0), "fetch", c == d, (c == d) ? w : $urandom, 0, sp_at == k);
      k++;
    end
    if (cls == 0) begin
      cycle(mk(0, 0, 0, 1, 0, 1, w), "decode", 0, $urandom, 0, sp_at == k); k++;
      cycle(mk(0, 0, 0, 1, 0, 1, w), "execute", 0, $urandom, 0, sp_at == k); k++;
      cycle(mk(0, 1, 1, 1, 0, 1, w), "writeback", 0, $urandom, 0, sp_at == k);
      if (m_cnt < CMAX) m_cnt++;
    end else if (cls == 1) begin
      cycle(mk(0, 1, 0, 1, 0, 1, w), "skip_decode", 0, $urandom, 0, sp_at == k);
    end else begin
      cycle(mk(0, 0, 0, 1, 0, 1, w), "illegal_decode", 0, $urandom, 0, 0);
      m_ill = 1;
    end
    if (cls != 2 && stop_pend) begin
      stop_pend = 0;
      at_idle = 1;
    end
  endtask

  vec_t tbl[5];
  logic [31:0] w;
  int d, sp;

  initial begin
    reset = 0; start = 0; stop = 0; imem_ack = 0; imem_rdata = 0;
    repeat (2) @(negedge clk);
    chk(mk(0, 0, 0, 0, 0, 0, 0), "reset_init");
    reset = 1;

    // Reset then ADD r3, r1, r2 with immediate ack
    tbl[0] = '{"t1_idle",    0, 32'h0,        1, 0, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{"t1_fetch",   1, 32'hE0813002, 0, 0, mk(1, 0, 0, 1, 0, 0, 0)};
    tbl[2] = '{"t1_decode",  0, 32'h0,        0, 0, mk(0, 0, 0, 1, 0, 1, 32'hE0813002)};
    tbl[3] = '{"t1_execute", 0, 32'h0,        0, 0, mk(0, 0, 0, 1, 0, 1, 32'hE0813002)};
    tbl[4] = '{"t1_wb",      0, 32'h0,        0, 0, mk(0, 1, 1, 1, 0, 1, 32'hE0813002)};
    for (int i = 0; i < 5; i++)
      cycle(tbl[i].e, tbl[i].nm, tbl[i].ack, tbl[i].rd, tbl[i].st, tbl[i].sp);
    m_cnt = 1; at_idle = 0;

    run_instr(32'hE2814005, 3, -1);        // ADDI, ack after 3 waits
    run_instr(32'h10813002, 0, -1);        // conditional skip
    run_instr(32'hE0813002, 0, 2);         // stop during EXECUTE
    cycle(mk(0, 0, 0, 0, 0, 0, 0), "stop_idle", 0, 0, 0, 1);
    launch();
    run_instr(32'hE2814005, TO - 1, -1);   // ack in the last allowed cycle
    if (at_idle) launch();
    run_instr(32'hE0813002, 0, -1);        // stop given in IDLE must not linger
    cycle(mk(1, 0, 0, 1, 0, 0, 0), "no_stale_stop", 1, 32'h10813002, 0, 0);
    cycle(mk(0, 1, 0, 1, 0, 1, 32'h10813002), "skip2", 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      if (at_idle) launch();
      w = rand_word();
      d = $urandom_range(0, 4);
      sp = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, d + 3)) : -1;
      run_instr(w, d, sp);
    end
    if (at_idle) launch();

    run_instr(32'hE0413002, 0, -1);        // SUB is illegal
    for (int i = 0; i < 3; i++)
      cycle(mk(0, 0, 0, 0, 1, 0, 0), "illegal_halt", 0, 0, 1, 1);
    do_reset(0);
    launch();

    for (int c = 0; c < TO; c++)
      cycle(mk(1, 0, 0, 1, 0, 0, 0), "to_fetch", 0, $urandom, 0, 0);
    m_tmo = 1;
    for (int i = 0; i < 2; i++)
      cycle(mk(0, 0, 0, 0, 1, 0, 0), "timeout_halt", 0, 0, 1, 0);
    do_reset(0);
    launch();

    run_instr(32'hE0813002, 1, -1);
    w = 32'hE2856007;
    cycle(mk(1, 0, 0, 1, 0, 0, 0), "mid_fetch", 1, w, 0, 0);
    cycle(mk(0, 0, 0, 1, 0, 1, w), "mid_decode", 0, 0, 0, 0);
    cycle(mk(0, 0, 0, 1, 0, 1, w), "mid_execute", 0, 0, 0, 0);
    cycle(mk(0, 1, 1, 1, 0, 1, w), "mid_wb", 0, 0, 0, 0);
    do_reset(1);                           // asynchronous drop inside WRITEBACK
    cycle(mk(0, 0, 0, 0, 0, 0, 0), "post_reset_idle", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_multicycle_ctrl.md
Name: cpu_multicycle_ctrl

Overview:
- Multicycle control FSM that sequences the CPU datapath: the program counter, instruction memory, register file and ALU.
- Fetches one 32-bit ARM data-processing word per instruction through a req/ack handshake to instruction memory, then decodes it.
- Executes only ADD (register) and ADD (immediate). It drives the register-file addresses, the ALU source select, the write enable and the PC advance strobe.
- Sits between Program_Counter/InstructionMemory and the register file/ALU in CPU_V1.

Parameters:
- DATA_W, 32, instruction/immediate width.
- COUNT_W, 16, width of the retired-instruction counter.
- IMEM_TIMEOUT, 15, maximum FETCH cycles without imem_ack before an error halt (must be ≥1).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  leaves IDLE when high.
- stop  in  1  request to stop at the next instruction boundary.
- imem_req  out  1  fetch request, held until imem_ack.
- imem_ack  in  1  instruction-memory data valid.
- imem_rdata  in  DATA_W  fetched instruction.
- pc_en  out  1  one-cycle PC+4 strobe.
- ra1  out  4  Rn = IR[19:16].
- ra2  out  4  Rm = IR[3:0].
- wa3  out  4  Rd = IR[15:12].
- alu_src_imm  out  1  1 selects imm_ext as ALU operand B.
- imm_ext  out  DATA_W  zero-extended IR[7:0].
- rf_we  out  1  register-file write enable.
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.
- illegal  out  1  sticky: unsupported instruction.
- timeout  out  1  sticky: imem_ack missing.
- instr_count  out  COUNT_W  retired ADD/ADDI count.

Behaviour:
- **Reset.** While reset=0, asynchronously: state=IDLE, IR=0, stop latch=0, timeout counter=0. All outputs are 0, and ra1/ra2/wa3/imm_ext=0. Reset mid-instruction drops rf_we and pc_en immediately.
- **States:** IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- **IDLE:**
  - start=1 → FETCH next cycle.
  - stop is ignored in IDLE and its latch is cleared.
- **FETCH:**
  - imem_req=1 every cycle in FETCH.
  - When imem_ack=1, IR<=imem_rdata and the state goes to DECODE. The timeout counter clears.
  - Otherwise the counter increments. When it reaches IMEM_TIMEOUT-1 without ack: timeout<=1, state goes to HALT.
  - If ack and counter expiry coincide, the ack wins.
- **DECODE** classifies IR:
  - **Execute:** cond=IR[31:28]=1110, op=IR[27:26]=00, cmd=IR[24:21]=0100, S=IR[20] don't-care, and either:
    - I=IR[25]=0 with IR[11:4]=0, or
    - I=1 with IR[11:8]=0 (no rotation).
    
    These go to EXECUTE.
  - **Skip:** cond≠1110 and the word is otherwise a legal ADD. pc_en=1 for one cycle, instr_count is unchanged, and the state goes to the boundary decision.
  - **Illegal:** anything else. illegal<=1, state → HALT, PC not advanced.
- **Decoded outputs.** ra1, ra2, wa3, alu_src_imm (=IR[25]) and imm_ext are combinational from IR. They are valid from DECODE through WRITEBACK and forced to 0 in IDLE/HALT.
- **EXECUTE:** one cycle for the ALU to settle; no strobes.
- **WRITEBACK:**
  - rf_we=1 and pc_en=1 in the same single cycle.
  - instr_count+=1, saturating at all-ones.
  - Then the boundary decision.
- **Boundary decision:**
  - If stop is latched (or stop=1 this cycle): → IDLE, latch cleared.
  - Else → FETCH.
- **stop** is latched in any busy state.
- **HALT:** absorbing. start and stop are ignored. Exit only via reset.
- **Latency:** 4 cycles per ADD/ADDI with zero-wait ack (FETCH, DECODE, EXECUTE, WRITEBACK). Each wait cycle adds 1. A skipped instruction takes 2 cycles.
- pc_en and rf_we are never asserted outside DECODE(skip) or WRITEBACK.

Test Plan:
1. **Reset then ADD.** Reset low, then start=1 with immediate ack and word 0xE0813002 → in cycle 4: rf_we=1, pc_en=1, ra1=1, ra2=2, wa3=3, alu_src_imm=0; instr_count=1; back to FETCH next cycle.
2. **ADDI.** Word 0xE2814005 → alu_src_imm=1, imm_ext=0x00000005, wa3=4, ra1=1. Ack delayed 3 cycles → rf_we appears 7 cycles after entering FETCH.
3. **Conditional skip.** Word 0x10813002 → pc_en pulses in DECODE, rf_we stays 0, instr_count unchanged, FETCH next.
4. **Illegal.** SUB 0xE0413002 → illegal=1, halted=1, pc_en never pulses. A later start=1 has no effect; after reset, illegal=0.
5. **Timeout.** Ack withheld for 15 FETCH cycles (default) → timeout=1, halted=1, imem_req=0. With ack exactly in the last cycle, no timeout.
6. **Stop and reset mid-instruction.** stop pulsed during EXECUTE → WRITEBACK completes, then IDLE, busy=0. Reset asserted during WRITEBACK → rf_we=0 immediately, state IDLE, instr_count=0.
